// File: rtl/hazard_ctrl.sv
// Producer side of the bypass network: tracks {opcode, rd} through X/M/W and
// stalls decode on uncovered load-use hazards and while a mul/div holds X.
module hazard_ctrl #(
    parameter int MD_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid_D,
    input  logic [4:0] opcode_D,
    input  logic [4:0] aluop_D,
    input  logic [4:0] rd_D,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       rs_used_D,
    input  logic       rt_used_D,
    input  logic       flush,
    output logic       stall,
    output logic       md_busy,
    output logic [4:0] opcode_X,
    output logic [4:0] rd_X,
    output logic [4:0] opcode_M,
    output logic [4:0] rd_M,
    output logic [4:0] opcode_W,
    output logic [4:0] rd_W
);

    localparam int CNT_W = $clog2(MD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_CYCLES - 1);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    logic [CNT_W-1:0] md_cnt;
    logic             busy;
    logic             is_md;
    logic             load_use;
    logic [4:0]       rd_entry;

    // NOTE: every signal gets a value on every path here, so no latch is inferred.
    always_comb begin
        rd_entry = (opcode_D inside {OP_R, OP_ADDI, OP_LW, OP_JAL, OP_SETX}) ? rd_D : 5'd0;
        is_md    = valid_D && (opcode_D == OP_R) && (aluop_D inside {ALU_MUL, ALU_DIV});
        busy     = (md_cnt != '0);
        load_use = !busy && valid_D && (opcode_X == OP_LW) && (rd_X != 5'd0) &&
                   ((rs_used_D && (rs_D == rd_X)) || (rt_used_D && (rt_D == rd_X)));
        stall    = busy || (load_use && !flush);
        md_busy  = busy;
    end

    // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opcode_X <= '0;
            rd_X     <= '0;
            opcode_M <= '0;
            rd_M     <= '0;
            opcode_W <= '0;
            rd_W     <= '0;
            md_cnt   <= '0;
        end else if (busy) begin
            // mul/div holds X; a branch cannot be in X, so flush is irrelevant here
            opcode_M <= '0;
            rd_M     <= '0;
            opcode_W <= opcode_M;
            rd_W     <= rd_M;
            md_cnt   <= md_cnt - 1'b1;
        end else begin
            opcode_W <= opcode_M;
            rd_W     <= rd_M;
            opcode_M <= opcode_X;
            rd_M     <= rd_X;
            if (!flush && !load_use && valid_D) begin
                opcode_X <= opcode_D;
                rd_X     <= rd_entry;
                if (is_md) begin
                    md_cnt <= MD_RELOAD;
                end
            end else begin
                opcode_X <= '0;
                rd_X     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed per-cycle
// expectations into a queue; a monitor pops and compares on each falling edge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       stall;
        logic       md_busy;
        logic [4:0] ox;
        logic [4:0] rx;
        logic [4:0] om;
        logic [4:0] rm;
        logic [4:0] ow;
        logic [4:0] rw;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valid_D = 1'b0;
    logic [4:0] opcode_D = '0, aluop_D = '0, rd_D = '0, rs_D = '0, rt_D = '0;
    logic       rs_used_D = 1'b0, rt_used_D = 1'b0, flush = 1'b0;
    logic       stall, md_busy;
    logic [4:0] opcode_X, rd_X, opcode_M, rd_M, opcode_W, rd_W;

    int   n_checks = 0;
    int   n_fail = 0;
    int   step_no = 0;
    exp_t exp_q[$];
    int   idx_q[$];

    hazard_ctrl #(.MD_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .valid_D(valid_D), .opcode_D(opcode_D),
        .aluop_D(aluop_D), .rd_D(rd_D), .rs_D(rs_D), .rt_D(rt_D),
        .rs_used_D(rs_used_D), .rt_used_D(rt_used_D), .flush(flush),
        .stall(stall), .md_busy(md_busy), .opcode_X(opcode_X), .rd_X(rd_X),
        .opcode_M(opcode_M), .rd_M(rd_M), .opcode_W(opcode_W), .rd_W(rd_W)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int idx, input logic [4:0] act, input logic [4:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0d expected %0d", idx, name, act, req);
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation every falling edge.
    initial begin
        exp_t e;
        int   idx;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                idx = idx_q.pop_front();
                check("stall",    idx, {4'd0, stall},   {4'd0, e.stall});
                check("md_busy",  idx, {4'd0, md_busy}, {4'd0, e.md_busy});
                check("opcode_X", idx, opcode_X, e.ox);
                check("rd_X",     idx, rd_X,     e.rx);
                check("opcode_M", idx, opcode_M, e.om);
                check("rd_M",     idx, rd_M,     e.rm);
                check("opcode_W", idx, opcode_W, e.ow);
                check("rd_W",     idx, rd_W,     e.rw);
            end
        end
    end

    function automatic exp_t mk(input logic st, input logic bz,
                                input logic [4:0] ox, rx, om, rm, ow, rw);
        exp_t e;
        e = {st, bz, ox, rx, om, rm, ow, rw};
        return e;
    endfunction

    task automatic expect_now(input exp_t e);
        step_no++;
        exp_q.push_back(e);
        idx_q.push_back(step_no);
    endtask

    // Apply decode inputs for one cycle (called at posedge+1) and log the
    // outputs expected during that cycle.
    task automatic step(input logic v, input logic [4:0] op, alu, rd, rs, rt,
                        input logic rsu, rtu, fl, input exp_t e);
        valid_D = v; opcode_D = op; aluop_D = alu; rd_D = rd; rs_D = rs; rt_D = rt;
        rs_used_D = rsu; rt_used_D = rtu; flush = fl;
        expect_now(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input exp_t e);
        step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e);
    endtask

    localparam logic [4:0] LW = 5'd8, SW = 5'd7, JAL = 5'd3, R = 5'd0;
    localparam logic [4:0] MUL = 5'd6, DIV = 5'd7;

    initial begin
        exp_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held, then released with three idle cycles.
        repeat (2) @(posedge clock);
        #1;
        expect_now(z);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) idle(z);

        // Load-use: lw r5 then add r6 <- r5.
        step(1, LW, 0, 5, 0, 0, 0, 0, 0, z);
        step(1, R, 0, 6, 5, 0, 1, 0, 0, mk(1, 0, LW, 5, 0, 0, 0, 0));
        step(1, R, 0, 6, 5, 0, 1, 0, 0, mk(0, 0, 0, 0, LW, 5, 0, 0));
        idle(mk(0, 0, R, 6, 0, 0, LW, 5));
        idle(mk(0, 0, 0, 0, R, 6, 0, 0));
        idle(mk(0, 0, 0, 0, 0, 0, R, 6));

        // No hazard: unused source, and lw to r0.
        step(1, LW, 0, 5, 0, 0, 0, 0, 0, z);
        step(1, R, 0, 6, 5, 1, 0, 1, 0, mk(0, 0, LW, 5, 0, 0, 0, 0));
        step(1, LW, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, R, 6, LW, 5, 0, 0));
        step(1, R, 0, 2, 0, 0, 1, 0, 0, mk(0, 0, LW, 0, R, 6, LW, 5));
        idle(mk(0, 0, R, 2, LW, 0, R, 6));
        idle(mk(0, 0, 0, 0, R, 2, LW, 0));
        idle(mk(0, 0, 0, 0, 0, 0, R, 2));

        // Flush cancels a load-use; the add never reaches X.
        step(1, LW, 0, 7, 0, 0, 0, 0, 0, z);
        step(1, R, 0, 4, 0, 7, 0, 1, 1, mk(0, 0, LW, 7, 0, 0, 0, 0));
        idle(mk(0, 0, 0, 0, LW, 7, 0, 0));
        idle(mk(0, 0, 0, 0, 0, 0, LW, 7));

        // Non-writers carry rd 0; jal carries r31.
        step(1, SW, 0, 9, 0, 0, 0, 0, 0, z);
        step(1, JAL, 0, 31, 0, 0, 0, 0, 0, mk(0, 0, SW, 0, 0, 0, 0, 0));
        idle(mk(0, 0, JAL, 31, SW, 0, 0, 0));
        idle(mk(0, 0, 0, 0, JAL, 31, SW, 0));
        idle(mk(0, 0, 0, 0, 0, 0, JAL, 31));

        // mul r3 holds X for 4 cycles; back-to-back div r8 waits; flush ignored while busy.
        step(1, R, MUL, 3, 0, 0, 0, 0, 0, z);
        step(1, R, DIV, 8, 0, 0, 0, 0, 0, mk(1, 1, R, 3, 0, 0, 0, 0));
        step(1, R, DIV, 8, 0, 0, 0, 0, 1, mk(1, 1, R, 3, 0, 0, 0, 0));
        step(1, R, DIV, 8, 0, 0, 0, 0, 0, mk(1, 1, R, 3, 0, 0, 0, 0));
        step(1, R, DIV, 8, 0, 0, 0, 0, 0, mk(0, 0, R, 3, 0, 0, 0, 0));
        idle(mk(1, 1, R, 8, R, 3, 0, 0));
        idle(mk(1, 1, R, 8, 0, 0, R, 3));

        // Asynchronous reset in the middle of the div hold.
        reset = 1'b1;
        expect_now(z);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(z);
        idle(z);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
